rle_expander: RTL

- Upstream stage of the pixel reorder stage in the decompressor.
- Reads run-length-encoded (count, value) pairs from the compressed source memory and writes the expanded byte stream into the intermediate RGB buffer.
- Its done pulse is the reorder stage's start.
- Multi-cycle FSM with registered read/write pointers and a run counter.

---
 rtl/rle_expander.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rle_expander.sv
// rle_expander: expands (count, value) byte pairs from the compressed source
// memory into the intermediate RGB buffer, one output word per cycle.
// Its done pulse starts the downstream pixel reorder stage.
// Optional: define RLE_CHECKSUM_EN to accumulate a modulo-2^DATA_W sum of
// every written word on the checksum port (tied to 0 otherwise).
module rle_expander #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int OUT_DEPTH = 49152
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_pairs,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_enable,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] out_len,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        IDLE, RD_CNT, LD_CNT, RD_VAL, LD_VAL, EXPAND, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(OUT_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] in_ptr_q, in_ptr_d;
    logic [ADDR_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [ADDR_W-1:0] npairs_q, npairs_d;
    logic [DATA_W-1:0] run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] out_len_q, out_len_d;
    logic              err_q, err_d;
    logic              accept;

    // Next-state and lookahead of the registered outputs. Write strobe,
    // address and data are computed for the state being entered, so they
    // are valid during the EXPAND cycle itself without any path from rd_data.
    always_comb begin
        state_d    = state_q;
        in_ptr_d   = in_ptr_q;
        pair_cnt_d = pair_cnt_q;
        npairs_d   = npairs_q;
        run_cnt_d  = run_cnt_q;
        value_d    = value_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        out_len_d  = out_len_q;
        err_d      = err_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    npairs_d   = num_pairs;
                    in_ptr_d   = '0;
                    pair_cnt_d = '0;
                    wr_addr_d  = '0;
                    out_len_d  = '0;
                    err_d      = 1'b0;
                    state_d    = (num_pairs == '0) ? DONE : RD_CNT;
                end
            end
            RD_CNT: state_d = LD_CNT;
            LD_CNT: begin
                run_cnt_d = rd_data;
                in_ptr_d  = in_ptr_q + ADDR_W'(1);
                state_d   = RD_VAL;
            end
            RD_VAL: state_d = LD_VAL;
            LD_VAL: begin
                value_d    = rd_data;
                in_ptr_d   = in_ptr_q + ADDR_W'(1);
                pair_cnt_d = pair_cnt_q + ADDR_W'(1);
                state_d    = (run_cnt_q == '0) ? NEXT : EXPAND;
            end
            EXPAND: begin
                // A strobe-less EXPAND cycle means the buffer was full on entry.
                if (wr_en_q) begin
                    out_len_d = out_len_q + ADDR_W'(1);
                    run_cnt_d = run_cnt_q - DATA_W'(1);
                    state_d   = (run_cnt_q == DATA_W'(1)) ? NEXT : EXPAND;
                end else begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            NEXT:    state_d = (pair_cnt_q == npairs_q) ? DONE : RD_CNT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == EXPAND && out_len_d != DEPTH) begin
            wr_en_d   = 1'b1;
            wr_addr_d = out_len_d;
            wr_data_d = value_d;
        end
        rd_addr_d = in_ptr_d;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State and output registers; reset aborts any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ptr_q   <= '0;
            pair_cnt_q <= '0;
            npairs_q   <= '0;
            run_cnt_q  <= '0;
            value_q    <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_len_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ptr_q   <= in_ptr_d;
            pair_cnt_q <= pair_cnt_d;
            npairs_q   <= npairs_d;
            run_cnt_q  <= run_cnt_d;
            value_q    <= value_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_len_q  <= out_len_d;
            err_q      <= err_d;
        end
    end

`ifdef RLE_CHECKSUM_EN
    logic [DATA_W-1:0] cks_q, cks_d;

    // Sum tracks the write strobe register so it changes with each write.
    always_comb begin
        cks_d = cks_q;
        if (accept)       cks_d = '0;
        else if (wr_en_d) cks_d = cks_q + wr_data_d;
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cks_q <= '0;
        else     cks_q <= cks_d;
    end

    assign checksum = cks_q;
`else
    assign checksum = '0;
`endif

    assign rd_addr   = rd_addr_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_enable = wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_len   = out_len_q;
    assign err       = err_q;

endmodule
